// File: rtl/lsu_pkg.sv
// ============================================================================
// Module : lsu_pkg
// Brief  : Shared constants, state encoding and request helpers for the LSU.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package lsu_pkg;

    localparam int unsigned LSU_XLEN = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
    localparam logic [1:0] ERR_ILLEGAL  = 2'b11;

    localparam logic [1:0] WB_SEL_MEM = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_e;

    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        if (we) begin
            return (f3 > F3_W);
        end
        return !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    endfunction

    // Size lives in funct3[1:0] for both loads and stores.
    function automatic logic addr_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b01:   return off[0];
            2'b10:   return (off != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wdata);
        case (f3[1:0])
            2'b00:   return {4{wdata[7:0]}};
            2'b01:   return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/load_align.sv
// ============================================================================
// Module : load_align
// Brief  : Selects the addressed byte/half of a read word and extends it.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [31:0] w_shifted;

    assign w_shifted = rdata_i >> {off_i, 3'b000};

    always_comb begin
        data_o = w_shifted;
        case (funct3_i)
            F3_B:    data_o = {{24{w_shifted[7]}}, w_shifted[7:0]};
            F3_H:    data_o = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_BU:   data_o = {24'h0, w_shifted[7:0]};
            F3_HU:   data_o = {16'h0, w_shifted[15:0]};
            default: data_o = w_shifted;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/load_store_unit.sv
// ============================================================================
// Module : load_store_unit
// Brief  : Memory-access stage: one outstanding load/store on a valid/ready bus.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned TO_CYCLES = 64
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_we_i,
    input  logic [2:0]      req_funct3_i,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [XLEN-1:0] req_wdata_i,
    input  logic [4:0]      req_rd_i,
    output logic            bus_valid_o,
    input  logic            bus_ready_i,
    output logic            bus_we_o,
    output logic [XLEN-1:0] bus_addr_o,
    output logic [3:0]      bus_be_o,
    output logic [XLEN-1:0] bus_wdata_o,
    input  logic            bus_rvalid_i,
    input  logic [XLEN-1:0] bus_rdata_i,
    output logic            wb_valid_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic [4:0]      wb_rd_o,
    output logic [1:0]      wb_sel_o,
    output logic            err_valid_o,
    output logic [1:0]      err_code_o
);

    localparam logic [7:0] C_TO_LAST = 8'(TO_CYCLES - 1);

    lsu_state_e      state_q, state_d;
    logic            we_q, we_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [1:0]      off_q, off_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [3:0]      be_q, be_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            wb_valid_q, wb_valid_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic            err_valid_q, err_valid_d;
    logic [1:0]      err_code_q, err_code_d;
    logic [XLEN-1:0] w_load_word;

    load_align u_load_align (
        .rdata_i  (bus_rdata_i),
        .off_i    (off_q),
        .funct3_i (funct3_q),
        .data_o   (w_load_word)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            funct3_q    <= 3'b000;
            off_q       <= 2'b00;
            rd_q        <= 5'd0;
            addr_q      <= '0;
            be_q        <= 4'b0000;
            wdata_q     <= '0;
            cnt_q       <= 8'd0;
            wb_valid_q  <= 1'b0;
            wb_data_q   <= '0;
            wb_rd_q     <= 5'd0;
            err_valid_q <= 1'b0;
            err_code_q  <= ERR_NONE;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            rd_q        <= rd_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            wb_valid_q  <= wb_valid_d;
            wb_data_q   <= wb_data_d;
            wb_rd_q     <= wb_rd_d;
            err_valid_q <= err_valid_d;
            err_code_q  <= err_code_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        rd_d        = rd_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        wb_valid_d  = 1'b0;
        wb_data_d   = wb_data_q;
        wb_rd_d     = wb_rd_q;
        err_valid_d = 1'b0;
        err_code_d  = err_code_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    // Illegal encoding takes priority over an alignment fault.
                    if (f3_illegal(req_we_i, req_funct3_i)) begin
                        err_valid_d = 1'b1;
                        err_code_d  = ERR_ILLEGAL;
                    end else if (addr_misaligned(req_funct3_i, req_addr_i[1:0])) begin
                        err_valid_d = 1'b1;
                        err_code_d  = ERR_MISALIGN;
                    end else begin
                        state_d  = ST_ISSUE;
                        we_d     = req_we_i;
                        funct3_d = req_funct3_i;
                        off_d    = req_addr_i[1:0];
                        rd_d     = req_rd_i;
                        addr_d   = {req_addr_i[XLEN-1:2], 2'b00};
                        be_d     = req_we_i ? store_be(req_funct3_i, req_addr_i[1:0]) : 4'b1111;
                        wdata_d  = req_we_i ? store_lanes(req_funct3_i, req_wdata_i) : '0;
                        cnt_d    = 8'd0;
                    end
                end
            end
            ST_ISSUE: begin
                cnt_d = cnt_q + 8'd1;
                if (bus_ready_i) begin
                    state_d = we_q ? ST_IDLE : ST_WAIT;
                end else if (cnt_q == C_TO_LAST) begin
                    state_d     = ST_IDLE;
                    err_valid_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (bus_rvalid_i) begin
                    state_d    = ST_RESP;
                    wb_valid_d = 1'b1;
                    wb_data_d  = w_load_word;
                    wb_rd_d    = rd_q;
                end else if (cnt_q == C_TO_LAST) begin
                    state_d     = ST_IDLE;
                    err_valid_d = 1'b1;
                    err_code_d  = ERR_TIMEOUT;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign req_ready_o = (state_q == ST_IDLE);
    assign bus_valid_o = (state_q == ST_ISSUE);
    assign bus_we_o    = we_q;
    assign bus_addr_o  = addr_q;
    assign bus_be_o    = be_q;
    assign bus_wdata_o = wdata_q;
    assign wb_valid_o  = wb_valid_q;
    assign wb_data_o   = wb_data_q;
    assign wb_rd_o     = wb_rd_q;
    assign wb_sel_o    = wb_valid_q ? WB_SEL_MEM : 2'b00;
    assign err_valid_o = err_valid_q;
    assign err_code_o  = err_code_q;

endmodule

`default_nettype wire

// File: tb/tb_load_store_unit.sv
// ============================================================================
// Module : tb_load_store_unit
// Brief  : Directed stimulus with queued expectations for the load/store unit.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_load_store_unit;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready_o;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [4:0]  req_rd = 5'd0;
    logic        bus_valid_o;
    logic        bus_ready = 1'b0;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_wdata_o;
    logic        bus_rvalid = 1'b0;
    logic [31:0] bus_rdata = 32'h0;
    logic        wb_valid_o;
    logic [31:0] wb_data_o;
    logic [4:0]  wb_rd_o;
    logic [1:0]  wb_sel_o;
    logic        err_valid_o;
    logic [1:0]  err_code_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        bit          cw;
    } bus_exp_t;

    typedef struct {
        bit          is_err;
        logic [31:0] data;
        logic [4:0]  rd;
        logic [1:0]  code;
    } rsp_exp_t;

    bus_exp_t bus_q[$];
    rsp_exp_t rsp_q[$];
    bus_exp_t mon_b;
    rsp_exp_t mon_r;

    load_store_unit #(.XLEN(32), .TO_CYCLES(TO)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready_o),
        .req_we_i     (req_we),
        .req_funct3_i (req_funct3),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .req_rd_i     (req_rd),
        .bus_valid_o  (bus_valid_o),
        .bus_ready_i  (bus_ready),
        .bus_we_o     (bus_we_o),
        .bus_addr_o   (bus_addr_o),
        .bus_be_o     (bus_be_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_rvalid_i (bus_rvalid),
        .bus_rdata_i  (bus_rdata),
        .wb_valid_o   (wb_valid_o),
        .wb_data_o    (wb_data_o),
        .wb_rd_o      (wb_rd_o),
        .wb_sel_o     (wb_sel_o),
        .err_valid_o  (err_valid_o),
        .err_code_o   (err_code_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_bus(input logic [31:0] a, input logic we, input logic [3:0] be,
                            input logic [31:0] wd, input bit cw);
        bus_exp_t b;
        b.addr = a; b.we = we; b.be = be; b.wdata = wd; b.cw = cw;
        bus_q.push_back(b);
    endtask

    task automatic push_rsp(input bit is_err, input logic [31:0] d, input logic [4:0] rd,
                            input logic [1:0] code);
        rsp_exp_t r;
        r.is_err = is_err; r.data = d; r.rd = rd; r.code = code;
        rsp_q.push_back(r);
    endtask

    // Presents one request for a single cycle; returns one cycle after acceptance.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd);
        req_valid = 1'b1; req_we = we; req_funct3 = f3;
        req_addr = a; req_wdata = wd; req_rd = rd;
        chk("req_ready_before_accept", req_ready_o, 1'b1);
        cyc();
        req_valid = 1'b0;
    endtask

    // Zero-wait load; optional junk RVALID on the handshake cycle must be ignored.
    task automatic do_load(input logic [2:0] f3, input logic [31:0] a, input logic [4:0] rd,
                           input logic [31:0] rdata, input logic [31:0] exp, input bit junk);
        push_bus({a[31:2], 2'b00}, 1'b0, 4'b1111, 32'h0, 1'b0);
        push_rsp(1'b0, exp, rd, 2'b00);
        bus_ready = 1'b1;
        issue(1'b0, f3, a, 32'h0, rd);
        chk("load_bus_valid", bus_valid_o, 1'b1);
        bus_rvalid = junk; bus_rdata = 32'h5555_AAAA;
        cyc();
        bus_ready = 1'b0; bus_rvalid = 1'b1; bus_rdata = rdata;
        cyc();
        bus_rvalid = 1'b0;
        chk("load_wb_latency", wb_valid_o, 1'b1);
        cyc();
        chk("load_wb_pulse", wb_valid_o, 1'b0);
        chk("load_back_idle", req_ready_o, 1'b1);
    endtask

    task automatic do_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] be, input logic [31:0] lanes, input int stall);
        push_bus({a[31:2], 2'b00}, 1'b1, be, lanes, 1'b1);
        bus_ready = 1'b0;
        issue(1'b1, f3, a, wd, 5'd0);
        for (int i = 0; i < stall; i++) begin
            chk("store_valid_held", bus_valid_o, 1'b1);
            chk("store_be_stable", bus_be_o, be);
            chk("store_wdata_stable", bus_wdata_o, lanes);
            cyc();
        end
        bus_ready = 1'b1;
        cyc();
        bus_ready = 1'b0;
        chk("store_valid_drop", bus_valid_o, 1'b0);
        chk("store_back_idle", req_ready_o, 1'b1);
        chk("store_no_wb", wb_valid_o, 1'b0);
    endtask

    task automatic do_err(input logic we, input logic [2:0] f3, input logic [31:0] a,
                          input logic [1:0] code);
        push_rsp(1'b1, 32'h0, 5'd0, code);
        bus_ready = 1'b1;
        issue(we, f3, a, 32'h0, 5'd1);
        chk("err_no_bus", bus_valid_o, 1'b0);
        chk("err_stay_idle", req_ready_o, 1'b1);
        chk("err_pulse", err_valid_o, 1'b1);
        cyc();
        bus_ready = 1'b0;
        chk("err_pulse_end", err_valid_o, 1'b0);
        chk("err_code_held", err_code_o, code);
    endtask

    // Scoreboard monitor: pops an expectation whenever the DUT presents something.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus_valid_o && bus_ready) begin
                if (bus_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL bus_unexpected: got addr %h expected no access", bus_addr_o);
                end else begin
                    mon_b = bus_q.pop_front();
                    chk("bus_addr", bus_addr_o, mon_b.addr);
                    chk("bus_we", bus_we_o, mon_b.we);
                    chk("bus_be", bus_be_o, mon_b.be);
                    if (mon_b.cw) chk("bus_wdata", bus_wdata_o, mon_b.wdata);
                end
            end
            if (wb_valid_o && err_valid_o) chk("wb_err_exclusive", 1'b1, 1'b0);
            if (wb_valid_o || err_valid_o) begin
                if (rsp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL rsp_unexpected: got wb %0d err %0d expected none",
                             wb_valid_o, err_valid_o);
                end else begin
                    mon_r = rsp_q.pop_front();
                    chk("rsp_kind_wb", wb_valid_o, !mon_r.is_err);
                    if (!mon_r.is_err) begin
                        chk("wb_data", wb_data_o, mon_r.data);
                        chk("wb_rd", wb_rd_o, mon_r.rd);
                        chk("wb_sel", wb_sel_o, 2'b01);
                    end else begin
                        chk("err_code", err_code_o, mon_r.code);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        repeat (2) cyc();
        rst = 1'b0;
        chk("rst_req_ready", req_ready_o, 1'b1);
        chk("rst_bus_valid", bus_valid_o, 1'b0);
        chk("rst_wb_valid", wb_valid_o, 1'b0);
        chk("rst_wb_data", wb_data_o, 32'h0);
        chk("rst_err", {err_valid_o, err_code_o}, 3'b000);
        chk("rst_bus_addr", bus_addr_o, 32'h0);

        do_load(3'b010, 32'h100, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
        do_load(3'b000, 32'h103, 5'd7, 32'h80FF_0000, 32'hFFFF_FF80, 1'b0);
        do_load(3'b100, 32'h103, 5'd8, 32'h80FF_0000, 32'h0000_0080, 1'b1);
        do_load(3'b001, 32'h102, 5'd9, 32'h80FF_0000, 32'hFFFF_80FF, 1'b0);
        do_load(3'b101, 32'h100, 5'd10, 32'h1234_F00D, 32'h0000_F00D, 1'b0);
        do_load(3'b000, 32'h101, 5'd0, 32'h0000_7F00, 32'h0000_007F, 1'b0);

        do_store(3'b001, 32'h202, 32'h1234ABCD, 4'b1100, 32'hABCDABCD, 3);
        do_store(3'b000, 32'h201, 32'h0000_005A, 4'b0010, 32'h5A5A5A5A, 0);
        do_store(3'b010, 32'h300, 32'hCAFEF00D, 4'b1111, 32'hCAFEF00D, 1);

        do_err(1'b0, 3'b010, 32'h101, 2'b01);
        do_err(1'b1, 3'b001, 32'h201, 2'b01);
        do_err(1'b0, 3'b011, 32'h100, 2'b11);
        do_err(1'b1, 3'b100, 32'h001, 2'b11);
        do_err(1'b0, 3'b110, 32'h003, 2'b11);

        // Load accepted by the bus but read data never arrives.
        push_bus(32'h400, 1'b0, 4'b1111, 32'h0, 1'b0);
        push_rsp(1'b1, 32'h0, 5'd0, 2'b10);
        bus_ready = 1'b1;
        issue(1'b0, 3'b010, 32'h400, 32'h0, 5'd3);
        n = 1;
        cyc();
        bus_ready = 1'b0;
        n++;
        while (!err_valid_o && n < 40) begin
            cyc();
            n++;
        end
        chk("load_timeout_latency", n, TO + 1);
        chk("load_timeout_bus_idle", bus_valid_o, 1'b0);
        bus_rvalid = 1'b1; bus_rdata = 32'h0BAD_0BAD;
        cyc();
        bus_rvalid = 1'b0;
        cyc();
        chk("late_rvalid_no_wb", wb_valid_o, 1'b0);
        chk("late_rvalid_idle", req_ready_o, 1'b1);

        // Store whose bus never accepts.
        push_rsp(1'b1, 32'h0, 5'd0, 2'b10);
        issue(1'b1, 3'b010, 32'h600, 32'h1, 5'd0);
        n = 1;
        while (!err_valid_o && n < 40) begin
            chk("store_to_valid_held", bus_valid_o, 1'b1);
            cyc();
            n++;
        end
        chk("store_timeout_latency", n, TO + 1);
        chk("store_timeout_bus_idle", bus_valid_o, 1'b0);
        cyc();

        // Reset while waiting for read data.
        push_bus(32'h500, 1'b0, 4'b1111, 32'h0, 1'b0);
        bus_ready = 1'b1;
        issue(1'b0, 3'b010, 32'h500, 32'h0, 5'd4);
        cyc();
        bus_ready = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus_rvalid = 1'b1; bus_rdata = 32'h1122_3344;
        cyc();
        bus_rvalid = 1'b0;
        chk("rstwait_wb_valid", wb_valid_o, 1'b0);
        chk("rstwait_req_ready", req_ready_o, 1'b1);
        chk("rstwait_wb_data", wb_data_o, 32'h0);
        chk("rstwait_wb_rd", wb_rd_o, 5'd0);
        chk("rstwait_bus", {bus_valid_o, bus_we_o, bus_be_o}, 6'h0);
        chk("rstwait_bus_addr", bus_addr_o, 32'h0);
        chk("rstwait_err", {err_valid_o, err_code_o}, 3'b000);
        cyc();
        chk("rstwait_still_no_wb", wb_valid_o, 1'b0);

        repeat (2) cyc();
        chk("bus_queue_drained", bus_q.size(), 0);
        chk("rsp_queue_drained", rsp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
